// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: datapath widths, branch opcodes and
// the operand record used by every reservation station.
package ooo_pkg;

  localparam int ROB_W  = 4;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JNZ = 4'b1001;
  localparam logic [3:0] OP_JS  = 4'b1010;
  localparam logic [3:0] OP_JNS = 4'b1011;

  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  tag;
  } operand_t;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [ROB_W-1:0] robIndex;
    logic [8:0]       imm;
    operand_t         t;
    operand_t         a;
  } br_entry_t;

  // Capture a CDB broadcast into an operand that is still waiting on that tag.
  function automatic operand_t wakeOperand(input operand_t          op,
                                           input logic              cdbValid,
                                           input logic [ROB_W-1:0]  cdbTag,
                                           input logic [DATA_W-1:0] cdbValue);
    operand_t res;
    res = op;
    if (cdbValid && !op.rdy && (op.tag == cdbTag)) begin
      res.rdy = 1'b1;
      res.val = cdbValue;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB, flush and issue signals of the branch reservation station.
// The station itself takes the slave side.
interface branch_rs_if #(
  parameter int ROB_W  = ooo_pkg::ROB_W,
  parameter int DATA_W = ooo_pkg::DATA_W
);

  logic              flush;

  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_opcode;
  logic [ROB_W-1:0]  disp_rob_index;
  logic              disp_t_rdy;
  logic              disp_a_rdy;
  logic [DATA_W-1:0] disp_t_val;
  logic [DATA_W-1:0] disp_a_val;
  logic [ROB_W-1:0]  disp_t_tag;
  logic [ROB_W-1:0]  disp_a_tag;
  logic [8:0]        disp_imm;

  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;

  logic              iss_valid;
  logic [3:0]        iss_opcode;
  logic [ROB_W-1:0]  iss_rob_index;
  logic [DATA_W-1:0] iss_vt;
  logic [DATA_W-1:0] iss_va;
  logic [8:0]        iss_imm;

  modport slave (
    input  flush,
    input  disp_valid, disp_opcode, disp_rob_index,
    input  disp_t_rdy, disp_a_rdy, disp_t_val, disp_a_val,
    input  disp_t_tag, disp_a_tag, disp_imm,
    input  cdb_valid, cdb_tag, cdb_value,
    output disp_ready,
    output iss_valid, iss_opcode, iss_rob_index, iss_vt, iss_va, iss_imm
  );

  modport master (
    output flush,
    output disp_valid, disp_opcode, disp_rob_index,
    output disp_t_rdy, disp_a_rdy, disp_t_val, disp_a_val,
    output disp_t_tag, disp_a_tag, disp_imm,
    output cdb_valid, cdb_tag, cdb_value,
    input  disp_ready,
    input  iss_valid, iss_opcode, iss_rob_index, iss_vt, iss_va, iss_imm
  );

endinterface

// File: rtl/branch_rs_age_picker.sv
// Age matrix that grants the oldest requesting entry; shared by the
// reservation stations. older_q[i][j] means entry i was allocated before j.
module age_picker #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  // A new allocation is younger than everything else currently in the matrix.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (i == j) begin
          older_d[i][j] = 1'b0;
        end else if (alloc_i[j]) begin
          older_d[i][j] = 1'b1;
        end else if (alloc_i[i]) begin
          older_d[i][j] = 1'b0;
        end else if (free_i[i] || free_i[j]) begin
          older_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && older_q[j][i]) begin
          grant_o[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: buffers branch uops, snoops the CDB for missing
// operands and issues the oldest ready entry through a registered packet.
module branch_rs
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  branch_rs_if.slave rs
);

  br_entry_t        entry_q [DEPTH];
  br_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [DEPTH-1:0] freeVec;
  logic [DEPTH-1:0] allocOh;
  logic [DEPTH-1:0] reqVec;
  logic [DEPTH-1:0] grantVec;
  logic [DEPTH-1:0] issueOh;
  logic [DEPTH-1:0] pickFree;
  logic             dispFire;
  logic             issueFire;
  br_entry_t        dispEntry;

  logic [3:0]        selOpcode;
  logic [ROB_W-1:0]  selRob;
  logic [DATA_W-1:0] selVt;
  logic [DATA_W-1:0] selVa;
  logic [8:0]        selImm;

  logic              issValid_q;
  logic [3:0]        issOpcode_q;
  logic [ROB_W-1:0]  issRob_q;
  logic [DATA_W-1:0] issVt_q;
  logic [DATA_W-1:0] issVa_q;
  logic [8:0]        issImm_q;

  assign freeVec       = ~valid_q;
  assign rs.disp_ready = |freeVec;
  assign dispFire      = rs.disp_valid && (|freeVec) && !rs.flush;

  // Scanning downwards leaves the lowest-numbered free slot selected.
  always_comb begin
    allocOh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (freeVec[i]) begin
        allocOh    = '0;
        allocOh[i] = dispFire;
      end
    end
  end

  always_comb begin
    reqVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      reqVec[i] = valid_q[i] && entry_q[i].t.rdy && entry_q[i].a.rdy;
    end
  end

  assign issueOh   = rs.flush ? '0 : grantVec;
  assign issueFire = |issueOh;
  assign pickFree  = rs.flush ? valid_q : issueOh;

  age_picker #(
    .DEPTH (DEPTH)
  ) u_age_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .alloc_i (allocOh),
    .free_i  (pickFree),
    .req_i   (reqVec),
    .grant_o (grantVec)
  );

  // A same-cycle CDB match is folded in here, or the entry would wait forever.
  always_comb begin
    dispEntry          = '0;
    dispEntry.opcode   = rs.disp_opcode;
    dispEntry.robIndex = rs.disp_rob_index;
    dispEntry.imm      = rs.disp_imm;
    dispEntry.t        = wakeOperand(operand_t'{rs.disp_t_rdy, rs.disp_t_val, rs.disp_t_tag},
                                     rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
    dispEntry.a        = wakeOperand(operand_t'{rs.disp_a_rdy, rs.disp_a_val, rs.disp_a_tag},
                                     rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i]   = entry_q[i];
      entry_d[i].t = wakeOperand(entry_q[i].t, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
      entry_d[i].a = wakeOperand(entry_q[i].a, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
      if (issueOh[i]) begin
        valid_d[i] = 1'b0;
      end
      if (allocOh[i]) begin
        valid_d[i] = 1'b1;
        entry_d[i] = dispEntry;
      end
    end
    if (rs.flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    selOpcode = '0;
    selRob    = '0;
    selVt     = '0;
    selVa     = '0;
    selImm    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grantVec[i]) begin
        selOpcode = entry_q[i].opcode;
        selRob    = entry_q[i].robIndex;
        selVt     = entry_q[i].t.val;
        selVa     = entry_q[i].a.val;
        selImm    = entry_q[i].imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Payload holds its last value when nothing issues; only the valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issValid_q  <= 1'b0;
      issOpcode_q <= '0;
      issRob_q    <= '0;
      issVt_q     <= '0;
      issVa_q     <= '0;
      issImm_q    <= '0;
    end else begin
      issValid_q <= issueFire;
      if (issueFire) begin
        issOpcode_q <= selOpcode;
        issRob_q    <= selRob;
        issVt_q     <= selVt;
        issVa_q     <= selVa;
        issImm_q    <= selImm;
      end
    end
  end

  assign rs.iss_valid     = issValid_q;
  assign rs.iss_opcode    = issOpcode_q;
  assign rs.iss_rob_index = issRob_q;
  assign rs.iss_vt        = issVt_q;
  assign rs.iss_va        = issVa_q;
  assign rs.iss_imm       = issImm_q;

endmodule

// File: tb/tb_branch_rs.sv
// Self-checking bench for branch_rs: directed scenarios with literal
// expectations plus randomized traffic against an age-ordered queue model.
module tb_branch_rs;
  import ooo_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    bit                dv;
    logic [3:0]        op;
    logic [ROB_W-1:0]  rob;
    logic [8:0]        imm;
    bit                trdy;
    logic [DATA_W-1:0] tval;
    logic [ROB_W-1:0]  ttag;
    bit                ardy;
    logic [DATA_W-1:0] aval;
    logic [ROB_W-1:0]  atag;
    bit                cv;
    logic [ROB_W-1:0]  ctag;
    logic [DATA_W-1:0] cval;
    bit                fl;
  } stim_t;

  typedef struct {
    logic [3:0]        op;
    logic [ROB_W-1:0]  rob;
    logic [8:0]        imm;
    bit                trdy;
    logic [DATA_W-1:0] tval;
    logic [ROB_W-1:0]  ttag;
    bit                ardy;
    logic [DATA_W-1:0] aval;
    logic [ROB_W-1:0]  atag;
  } mEntry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   checkEn = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  branch_rs_if ifc ();

  branch_rs #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: entries kept oldest-first in a queue.
  mEntry_t           mq[$];
  bit                mIssValid = 1'b0;
  logic [3:0]        mIssOp    = '0;
  logic [ROB_W-1:0]  mIssRob   = '0;
  logic [DATA_W-1:0] mIssVt    = '0;
  logic [DATA_W-1:0] mIssVa    = '0;
  logic [8:0]        mIssImm   = '0;

  always @(posedge clk or negedge rst_n) begin : model
    int      k;
    bit      wasFull;
    mEntry_t e;
    if (!rst_n) begin
      mq.delete();
      mIssValid = 1'b0;
      mIssOp = '0; mIssRob = '0; mIssVt = '0; mIssVa = '0; mIssImm = '0;
    end else begin
      wasFull = (mq.size() >= DEPTH);
      k = -1;
      foreach (mq[i]) if (k < 0 && mq[i].trdy && mq[i].ardy) k = i;
      if (ifc.flush) begin
        mq.delete();
        mIssValid = 1'b0;
      end else begin
        if (k >= 0) begin
          mIssValid = 1'b1;
          mIssOp  = mq[k].op;   mIssRob = mq[k].rob;
          mIssVt  = mq[k].tval; mIssVa  = mq[k].aval;
          mIssImm = mq[k].imm;
          mq.delete(k);
        end else begin
          mIssValid = 1'b0;
        end
        if (ifc.cdb_valid) begin
          foreach (mq[i]) begin
            if (!mq[i].trdy && mq[i].ttag == ifc.cdb_tag) begin
              mq[i].trdy = 1'b1; mq[i].tval = ifc.cdb_value;
            end
            if (!mq[i].ardy && mq[i].atag == ifc.cdb_tag) begin
              mq[i].ardy = 1'b1; mq[i].aval = ifc.cdb_value;
            end
          end
        end
        if (ifc.disp_valid && !wasFull) begin
          e.op = ifc.disp_opcode; e.rob = ifc.disp_rob_index; e.imm = ifc.disp_imm;
          e.trdy = ifc.disp_t_rdy; e.tval = ifc.disp_t_val; e.ttag = ifc.disp_t_tag;
          e.ardy = ifc.disp_a_rdy; e.aval = ifc.disp_a_val; e.atag = ifc.disp_a_tag;
          if (ifc.cdb_valid && !e.trdy && e.ttag == ifc.cdb_tag) begin
            e.trdy = 1'b1; e.tval = ifc.cdb_value;
          end
          if (ifc.cdb_valid && !e.ardy && e.atag == ifc.cdb_tag) begin
            e.ardy = 1'b1; e.aval = ifc.cdb_value;
          end
          mq.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("iss_valid",     32'(ifc.iss_valid),     32'(mIssValid));
      checkOutput("iss_opcode",    32'(ifc.iss_opcode),    32'(mIssOp));
      checkOutput("iss_rob_index", 32'(ifc.iss_rob_index), 32'(mIssRob));
      checkOutput("iss_vt",        32'(ifc.iss_vt),        32'(mIssVt));
      checkOutput("iss_va",        32'(ifc.iss_va),        32'(mIssVa));
      checkOutput("iss_imm",       32'(ifc.iss_imm),       32'(mIssImm));
      checkOutput("disp_ready",    32'(ifc.disp_ready),    32'(mq.size() < DEPTH));
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t dispStim(input logic [3:0] op, input logic [ROB_W-1:0] rob,
                                     input bit trdy, input logic [DATA_W-1:0] tval,
                                     input logic [ROB_W-1:0] ttag,
                                     input bit ardy, input logic [DATA_W-1:0] aval,
                                     input logic [ROB_W-1:0] atag, input logic [8:0] imm);
    stim_t s;
    s = idleStim();
    s.dv = 1'b1; s.op = op; s.rob = rob; s.imm = imm;
    s.trdy = trdy; s.tval = tval; s.ttag = ttag;
    s.ardy = ardy; s.aval = aval; s.atag = atag;
    return s;
  endfunction

  // One cycle: inputs change 2ns after the edge and are sampled at the next one.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #2;
    ifc.disp_valid = s.dv;   ifc.disp_opcode = s.op;  ifc.disp_rob_index = s.rob;
    ifc.disp_imm   = s.imm;
    ifc.disp_t_rdy = s.trdy; ifc.disp_t_val = s.tval; ifc.disp_t_tag = s.ttag;
    ifc.disp_a_rdy = s.ardy; ifc.disp_a_val = s.aval; ifc.disp_a_tag = s.atag;
    ifc.cdb_valid  = s.cv;   ifc.cdb_tag    = s.ctag; ifc.cdb_value  = s.cval;
    ifc.flush      = s.fl;
  endtask

  initial begin
    stim_t s;
    ifc.disp_valid = 1'b0; ifc.disp_opcode = '0; ifc.disp_rob_index = '0; ifc.disp_imm = '0;
    ifc.disp_t_rdy = 1'b0; ifc.disp_t_val = '0; ifc.disp_t_tag = '0;
    ifc.disp_a_rdy = 1'b0; ifc.disp_a_val = '0; ifc.disp_a_tag = '0;
    ifc.cdb_valid  = 1'b0; ifc.cdb_tag = '0; ifc.cdb_value = '0;
    ifc.flush      = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_iss_valid",  32'(ifc.iss_valid),  32'd0);
    checkOutput("reset_disp_ready", 32'(ifc.disp_ready), 32'd1);
    checkOutput("reset_iss_vt",     32'(ifc.iss_vt),     32'd0);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    // Ready dispatch: two-edge latency, single-cycle valid.
    applyStimulus(dispStim(OP_JZ, 4'd3, 1'b1, 16'h0040, 4'd0, 1'b1, 16'h0000, 4'd0, 9'h011));
    applyStimulus(idleStim());
    checkOutput("t1_not_yet", 32'(ifc.iss_valid), 32'd0);
    applyStimulus(idleStim());
    checkOutput("t1_valid",  32'(ifc.iss_valid),     32'd1);
    checkOutput("t1_opcode", 32'(ifc.iss_opcode),    32'd8);
    checkOutput("t1_rob",    32'(ifc.iss_rob_index), 32'd3);
    checkOutput("t1_vt",     32'(ifc.iss_vt),        32'h0040);
    checkOutput("t1_va",     32'(ifc.iss_va),        32'h0000);
    checkOutput("t1_imm",    32'(ifc.iss_imm),       32'h011);
    applyStimulus(idleStim());
    checkOutput("t1_one_cycle", 32'(ifc.iss_valid), 32'd0);

    // Deferred operand woken by the CDB.
    applyStimulus(dispStim(OP_JNZ, 4'd5, 1'b1, 16'h0100, 4'd0, 1'b0, 16'h0000, 4'd2, 9'h000));
    repeat (3) applyStimulus(idleStim());
    checkOutput("t2_waiting", 32'(ifc.iss_valid), 32'd0);
    s = idleStim(); s.cv = 1'b1; s.ctag = 4'd2; s.cval = 16'h0007;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("t2_after_capture", 32'(ifc.iss_valid), 32'd0);
    applyStimulus(idleStim());
    checkOutput("t2_valid", 32'(ifc.iss_valid),     32'd1);
    checkOutput("t2_rob",   32'(ifc.iss_rob_index), 32'd5);
    checkOutput("t2_va",    32'(ifc.iss_va),        32'h0007);

    // Dispatch/CDB bypass.
    s = dispStim(OP_JS, 4'd6, 1'b1, 16'h0200, 4'd0, 1'b0, 16'h0000, 4'd9, 9'h005);
    s.cv = 1'b1; s.ctag = 4'd9; s.cval = 16'h0001;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("t3_not_yet", 32'(ifc.iss_valid), 32'd0);
    applyStimulus(idleStim());
    checkOutput("t3_valid",  32'(ifc.iss_valid),  32'd1);
    checkOutput("t3_opcode", 32'(ifc.iss_opcode), 32'hA);
    checkOutput("t3_va",     32'(ifc.iss_va),     32'h0001);

    // Fill, then release all four with one broadcast: oldest first.
    for (int r = 1; r <= 4; r++)
      applyStimulus(dispStim(OP_JZ, 4'(r), 1'b1, 16'(r * 16), 4'd0, 1'b0, 16'h0, 4'd7, 9'(r)));
    applyStimulus(idleStim());
    checkOutput("t4_full", 32'(ifc.disp_ready), 32'd0);
    s = idleStim(); s.cv = 1'b1; s.ctag = 4'd7; s.cval = 16'h0055;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("t4_selecting_ready", 32'(ifc.disp_ready), 32'd0);
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(idleStim());
      checkOutput("t4_valid", 32'(ifc.iss_valid),     32'd1);
      checkOutput("t4_rob",   32'(ifc.iss_rob_index), 32'(r));
      checkOutput("t4_va",    32'(ifc.iss_va),        32'h0055);
      if (r == 1) checkOutput("t4_ready_back", 32'(ifc.disp_ready), 32'd1);
    end
    applyStimulus(idleStim());
    checkOutput("t4_drained", 32'(ifc.iss_valid), 32'd0);

    // Flush kills entries, the pending issue and a same-cycle dispatch.
    applyStimulus(dispStim(OP_JZ, 4'd1, 1'b1, 16'h1, 4'd0, 1'b0, 16'h0, 4'hA, 9'h0));
    applyStimulus(dispStim(OP_JZ, 4'd2, 1'b1, 16'h2, 4'd0, 1'b0, 16'h0, 4'hA, 9'h0));
    applyStimulus(dispStim(OP_JZ, 4'd3, 1'b1, 16'h3, 4'd0, 1'b1, 16'h3, 4'd0, 9'h0));
    s = dispStim(OP_JNZ, 4'd4, 1'b1, 16'h4, 4'd0, 1'b1, 16'h4, 4'd0, 9'h0);
    s.fl = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("t5_no_issue",   32'(ifc.iss_valid),  32'd0);
    checkOutput("t5_disp_ready", 32'(ifc.disp_ready), 32'd1);
    s = idleStim(); s.cv = 1'b1; s.ctag = 4'hA; s.cval = 16'h00AA;
    applyStimulus(s);
    repeat (3) begin
      applyStimulus(idleStim());
      checkOutput("t5_stays_empty", 32'(ifc.iss_valid), 32'd0);
    end

    // Asynchronous reset in the middle of an issue cycle.
    applyStimulus(dispStim(OP_JNS, 4'hC, 1'b1, 16'h1234, 4'd0, 1'b1, 16'h8000, 4'd0, 9'h1FF));
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("t6_pre_valid", 32'(ifc.iss_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid",  32'(ifc.iss_valid),     32'd0);
    checkOutput("t6_rst_opcode", 32'(ifc.iss_opcode),    32'd0);
    checkOutput("t6_rst_rob",    32'(ifc.iss_rob_index), 32'd0);
    checkOutput("t6_rst_vt",     32'(ifc.iss_vt),        32'd0);
    checkOutput("t6_rst_imm",    32'(ifc.iss_imm),       32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(dispStim(OP_JZ, 4'd9, 1'b1, 16'h0077, 4'd0, 1'b1, 16'h0001, 4'd0, 9'h0));
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("t6_after_valid", 32'(ifc.iss_valid),     32'd1);
    checkOutput("t6_after_rob",   32'(ifc.iss_rob_index), 32'd9);

    // Randomized traffic; narrow tag space so wakeups are frequent.
    for (int n = 0; n < 600; n++) begin
      s = idleStim();
      s.dv   = ($urandom_range(0, 9) < 6);
      s.op   = 4'($urandom_range(8, 11));
      s.rob  = 4'($urandom);
      s.imm  = 9'($urandom);
      s.trdy = ($urandom_range(0, 1) == 1);
      s.tval = 16'($urandom);
      s.ttag = 4'($urandom_range(0, 3));
      s.ardy = ($urandom_range(0, 1) == 1);
      s.aval = 16'($urandom);
      s.atag = 4'($urandom_range(0, 3));
      s.cv   = ($urandom_range(0, 9) < 4);
      s.ctag = 4'($urandom_range(0, 3));
      s.cval = 16'($urandom);
      s.fl   = ($urandom_range(0, 39) == 0);
      applyStimulus(s);
    end
    repeat (6) applyStimulus(idleStim());

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
